// File: rtl/dtb_trace_capture.sv
// dtb_trace_capture: trace-mode BRAM writer; clk/rst, control byte in, trace_i/trg_i samples in, wr_* BRAM port, status_o/event_addr_o/done_o out
module dtb_trace_capture #(
  parameter int TRB_WIDTH      = 32,
  parameter int TRB_DEPTH      = 32,
  parameter int TRB_ADDR_WIDTH = 8,
  parameter int TRB_MAX_TRACES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   control_i,
  input  logic                         control_valid_i,
  input  logic [TRB_MAX_TRACES-1:0]    trace_i,
  input  logic                         trg_i,
  output logic                         wr_en_o,
  output logic [TRB_ADDR_WIDTH-1:0]    wr_addr_o,
  output logic [TRB_WIDTH-1:0]         wr_data_o,
  output logic [7:0]                   status_o,
  output logic [$clog2(TRB_DEPTH)-1:0] event_addr_o,
  output logic                         done_o
);
  localparam int AW  = $clog2(TRB_DEPTH);
  localparam int PW  = $clog2(TRB_WIDTH);
  localparam int CW  = AW + 1;
  localparam int WPD = TRB_DEPTH / 16;
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3;
  logic [1:0]                state_q, state_d;
  logic [5:0]                cfg_q, cfg_d;
  logic [PW-1:0]             ptr_q, ptr_d, pos_q, pos_d;
  logic [AW-1:0]             addr_q, addr_d, wr_addr_q, wr_addr_d, eaddr_q, eaddr_d;
  logic [TRB_WIDTH-1:0]      sr_q, sr_d, wr_data_q, wr_data_d, merged;
  logic [CW-1:0]             cnt_q, cnt_d, cnt_base, post_n;
  logic                      wr_en_q, wr_en_d, trg_q, trg_d, done_q, done_d;
  logic [PW:0]               sw, ptr_nx;
  logic [7:0]                mask;
  logic [TRB_MAX_TRACES-1:0] smp;
  logic                      cmpl, trig;
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    ptr_d     = ptr_q;
    pos_d     = pos_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    eaddr_d   = eaddr_q;
    sr_d      = sr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    trg_d     = trg_q;
    done_d    = done_q;
    sw        = (PW+1)'(1) << cfg_q[5:4];
    mask      = cfg_q[5:4] == 2'd3 ? 8'hFF : cfg_q[5:4] == 2'd2 ? 8'h0F : cfg_q[5:4] == 2'd1 ? 8'h03 : 8'h01;
    smp       = trace_i & TRB_MAX_TRACES'(mask);
    merged    = sr_q | (TRB_WIDTH'(smp) << ptr_q);
    ptr_nx    = {1'b0, ptr_q} + sw;
    cmpl      = ptr_nx == (PW+1)'(TRB_WIDTH);
    trig      = state_q == ARMED && trg_i;
    post_n    = CW'((32'(cfg_q[3:0]) + 1) * WPD);
    // the trigger word itself is the first post word, so it may be the one that completes now
    cnt_base  = trig ? post_n : cnt_q;
    if (control_valid_i) begin
      cfg_d   = control_i[5:0];
      state_d = control_i[7:6] == 2'b00 ? ARMED : IDLE;
      ptr_d   = '0;
      addr_d  = '0;
      sr_d    = '0;
      trg_d   = 1'b0;
      pos_d   = '0;
      eaddr_d = '0;
      done_d  = 1'b0;
    end else if (state_q == ARMED || state_q == POST) begin
      ptr_d     = ptr_nx[PW-1:0];
      sr_d      = cmpl ? '0 : merged;
      wr_en_d   = cmpl;
      wr_addr_d = cmpl ? addr_q : wr_addr_q;
      wr_data_d = cmpl ? merged : wr_data_q;
      addr_d    = cmpl ? addr_q + 1'b1 : addr_q;
      cnt_d     = cmpl ? cnt_base - 1'b1 : cnt_base;
      if (trig) begin
        trg_d   = 1'b1;
        pos_d   = ptr_q;
        eaddr_d = addr_q;
        state_d = POST;
      end
      if ((trig || state_q == POST) && cmpl && cnt_base == CW'(1)) state_d = DONE;
    end else if (state_q == DONE) begin
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cfg_q     <= 6'h0F;
      ptr_q     <= '0;
      pos_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      eaddr_q   <= '0;
      sr_q      <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      trg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      ptr_q     <= ptr_d;
      pos_q     <= pos_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      eaddr_q   <= eaddr_d;
      sr_q      <= sr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      trg_q     <= trg_d;
      done_q    <= done_d;
    end
  end
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = TRB_ADDR_WIDTH'(wr_addr_q);
  assign wr_data_o    = wr_data_q;
  assign status_o     = {trg_q, 5'(pos_q), 2'b00};
  assign event_addr_o = eaddr_q;
  assign done_o       = done_q;
endmodule

// File: doc/dtb_trace_capture.md
Name: dtb_trace_capture

Overview:
- Trace-mode write side of the Data Trace Buffer.
- Consumes the host-written control byte (mode, trace count, post-trigger delay).
- Packs incoming trace samples into TRB_WIDTH-bit words and writes them circularly into trace BRAM.
- Stops after a programmed post-trigger fill and produces the status byte (trg_event, event_pos) that the host reads back.

Parameters:
- TRB_WIDTH, 32, BRAM word width; power of two.
- TRB_DEPTH, 32, BRAM words; power of two, multiple of 16.
- TRB_ADDR_WIDTH, 8, width of wr_addr_o; must be at least clog2(TRB_DEPTH).
- TRB_MAX_TRACES, 16, width of trace_i.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- control_i  in  8  control byte: [7:6] trg_mode, [5:4] trg_num_traces, [3:0] trg_delay.
- control_valid_i  in  1  one-cycle strobe; latches control_i and re-arms.
- trace_i  in  TRB_MAX_TRACES  trace sample, one per cycle.
- trg_i  in  1  trigger event, qualified per sample.
- wr_en_o  out  1  BRAM write strobe.
- wr_addr_o  out  TRB_ADDR_WIDTH  BRAM word address.
- wr_data_o  out  TRB_WIDTH  packed word.
- status_o  out  8  status byte: [7] trg_event, [6:2] event_pos, [1:0] zero.
- event_addr_o  out  clog2(TRB_DEPTH)  word address containing the trigger sample.
- done_o  out  1  capture finished; buffer frozen.

Behaviour:
- Reset: state IDLE; control = default (trace mode, num_traces 0, delay 4'hF).
  - bit pointer 0, word address 0, shift register 0.
  - wr_en_o, wr_addr_o, wr_data_o, status_o, event_addr_o, done_o all 0.
  - rst mid-capture aborts the capture immediately; no partial word is written.
- Sample width: SW = 1 << trg_num_traces (1, 2, 4 or 8 bits).
  - Sample is trace_i[SW-1:0]; upper bits are ignored.
  - Samples per word = TRB_WIDTH/SW.
- States: IDLE, ARMED, POST, DONE.
  - IDLE -> ARMED: control_valid_i with trg_mode = 00. Clears bit pointer, word address, partial word, status, done_o.
  - IDLE: control_valid_i with any other mode latches control and stays IDLE.
  - ARMED, POST: sample packed every cycle at bits [ptr+SW-1:ptr], LSB first.
    - ptr += SW, modulo TRB_WIDTH.
    - When ptr+SW = TRB_WIDTH, the word completes.
    - Next cycle: wr_en_o = 1 for exactly one cycle, with wr_addr_o = current word address and wr_data_o = the completed word. Latency is 1 cycle.
    - Word address then increments, wrapping TRB_DEPTH-1 -> 0.
  - ARMED -> POST: trg_i = 1 on a sample.
    - Latch event_pos = ptr of that sample and event_addr = current word address.
    - Set trg_event.
    - Load post counter = (trg_delay+1)*TRB_DEPTH/16 words, including the trigger word.
    - status_o and event_addr_o are updated the cycle after trg_i.
  - POST: counter decrements on each completed word.
  - POST -> DONE: after the word that brings the counter to 0 is written.
    - done_o = 1 from the cycle after that write.
  - DONE: no writes; status_o, event_addr_o and done_o held.
    - Left only via control_valid_i, which re-arms or goes to IDLE per mode.
- Re-arm mid-capture (control_valid_i in ARMED/POST/DONE):
  - Discards the partial word; restarts at address 0 with status cleared.
  - Applies the new SW from the next cycle.
  - Any wr_en_o already scheduled for a word completed in that same cycle is still issued.
- Simultaneous events:
  - control_valid_i and trg_i in the same cycle: control wins; trigger ignored.
  - trg_i in IDLE, POST or DONE: ignored; the first trigger is final.
  - Trigger on the last sample of a word: that word counts as the first post word.
- Delay 4'hF: post count = TRB_DEPTH, so the trigger word is the oldest word in the buffer.
- event_pos is in bits; it is always a multiple of SW and less than TRB_WIDTH.

Test Plan:
- Reset values: assert rst for 3 cycles mid-capture -> all outputs 0 in the cycle after rst, no wr_en_o pulse, state IDLE.
- Packing, 8-bit samples: control 8'h30, trace_i = 1, 2, 3, 4, ... -> wr_en_o one cycle after sample 4, addr 0, data 32'h04030201; next word addr 1, data 32'h08070605.
- Trigger, 1-bit samples, delay 0 (control 8'h00): trg_i on sample 5 of word 3 -> status_o 8'h94, event_addr_o 3.
  - Exactly words 3 and 4 written after the trigger.
  - done_o = 1 the cycle after word 4's write; no further writes.
- Trigger, 8-bit samples: control 8'h3F, trg_i on sample 2 of word 0 -> status_o 8'hC0.
  - Address wraps 31 -> 0.
  - 32 words written from word 0 inclusive, then done_o.
- Conflicts: trg_i together with control_valid_i -> no trigger, status 0.
  - Second trg_i in POST -> status unchanged.
  - control_valid_i with mode 01 -> state IDLE, no writes.
- Re-arm mid-POST with control 8'h10 -> status cleared, done_o 0, next word written at addr 0 packed with 2-bit samples.
